// File: rtl/count4_arb.sv
// -----------------------------------------------------------------------------
// count4_arb
//
// Round-robin arbiter that hands one of four requesters ownership of a shared
// 4-bit counter. Each grant goes through LOAD (counter cleared), HOLD (counter
// runs as a tenure timer) and RELEASE (pointer advances and the next winner is
// picked). The current owner is preempted when its tenure reaches HOLD_MAX
// HOLD cycles while some other requester is waiting.
//
// Parameters:
//   HOLD_MAX  maximum HOLD cycles per grant while others wait (legal 1..15)
//
// Ports:
//   clock      single clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   req[3:0]   request per requester (bit i = requester i)
//   count[3:0] current value of the shared counter
//   gnt[3:0]   one-hot grant, all-zero when nobody owns the counter
//   owner[1:0] index of the current or most recent owner
//   cnt_clr    synchronous clear strobe to the counter
//   cnt_en     increment enable to the counter
//   preempt    one-cycle pulse in the RELEASE cycle caused by tenure expiry
//   busy       high in every state except IDLE
//   dbg_state  raw FSM state (IDLE=0, LOAD=1, HOLD=2, RELEASE=3)
//
// Handshake: a requester raises req[i] and keeps it high until it sees
// gnt[i]; it keeps ownership while req[i] stays high (subject to preemption)
// and gives it up by dropping req[i]. Dropping req[i] before being granted is
// harmless. A RELEASE cycle with gnt=0 always separates two grants.
// -----------------------------------------------------------------------------
module count4_arb #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] count,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic       preempt,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Counter value at which the tenure is considered expired.
  localparam logic [3:0] LAST = 4'(HOLD_MAX - 1);

  state_t     state;
  state_t     state_nx;
  logic [1:0] ptr;
  logic [1:0] ptr_nx;
  logic [1:0] owner_nx;
  logic [3:0] gnt_nx;
  logic       cnt_clr_nx;
  logic       cnt_en_nx;
  logic       preempt_nx;
  logic       busy_nx;
  logic [3:0] count_pred;
  logic [2:0] pick_ptr;
  logic [2:0] pick_rel;

  // Round-robin search: starting at 'start', ascending modulo 4, the first
  // set bit wins. Result is {found, index}. The loop runs from the farthest
  // offset down so the nearest set bit overwrites the others.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Arbitration from IDLE uses the stored pointer; from RELEASE it starts
  // just after the releasing owner, which makes that owner lowest priority.
  always_comb begin
    pick_ptr = rr_pick(req, ptr);
    pick_rel = rr_pick(req, owner + 2'd1);
  end

  // Next-state logic.
  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    ptr_nx     = ptr;
    preempt_nx = 1'b0;

    case (state)
      IDLE: begin
        if (pick_ptr[2]) begin
          state_nx = LOAD;
          owner_nx = pick_ptr[1:0];
        end
      end

      LOAD: begin
        if (!req[owner]) state_nx = RELEASE;
        else             state_nx = HOLD;
      end

      HOLD: begin
        // Voluntary release is checked first, so a simultaneous release and
        // expiry is reported as voluntary (no preempt).
        if (!req[owner]) begin
          state_nx = RELEASE;
        end else if (count == LAST && (req & ~gnt) != 4'd0) begin
          state_nx   = RELEASE;
          preempt_nx = 1'b1;
        end
      end

      RELEASE: begin
        ptr_nx = owner + 2'd1;
        if (pick_rel[2]) begin
          state_nx = LOAD;
          owner_nx = pick_rel[1:0];
        end else begin
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Output decode for the state being entered. All outputs are registered so
  // nothing reaches a port combinationally from req or count. cnt_en must
  // reflect the counter value seen during the next cycle, so that value is
  // predicted from the strobes this block is driving right now.
  always_comb begin
    count_pred = cnt_clr ? 4'd0 : (count + {3'd0, cnt_en});

    gnt_nx     = 4'd0;
    cnt_clr_nx = 1'b0;
    cnt_en_nx  = 1'b0;
    busy_nx    = (state_nx != IDLE);

    case (state_nx)
      LOAD: begin
        gnt_nx     = 4'b0001 << owner_nx;
        cnt_clr_nx = 1'b1;
      end
      HOLD: begin
        gnt_nx    = 4'b0001 << owner_nx;
        // Saturate at LAST: the counter never wraps during a tenure.
        cnt_en_nx = (count_pred != LAST);
      end
      default: begin
        gnt_nx = 4'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      owner   <= 2'd0;
      gnt     <= 4'd0;
      cnt_clr <= 1'b0;
      cnt_en  <= 1'b0;
      preempt <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      owner   <= owner_nx;
      gnt     <= gnt_nx;
      cnt_clr <= cnt_clr_nx;
      cnt_en  <= cnt_en_nx;
      preempt <= preempt_nx;
      busy    <= busy_nx;
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/count4_arb.md
COUNT4_ARB -- requirements
Module: count4_arb

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum HOLD-state cycles per grant while others wait; legal range 1..15.
REQ-002 Port: clock  input  1  single clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester request for the shared 4-bit counter; bit i = requester i.
REQ-005 Port: count  input  4  current value of the shared 4-bit counter.
REQ-006 Port: gnt  output  4  one-hot grant; all-zero when no owner.
REQ-007 Port: owner  output  2  index of the current or last owner.
REQ-008 Port: cnt_clr  output  1  synchronous clear strobe to the counter.
REQ-009 Port: cnt_en  output  1  increment enable to the counter.
REQ-010 Port: preempt  output  1  one-cycle pulse when a grant is revoked by tenure expiry.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, HOLD and RELEASE; all outputs SHALL be functions of registered state only, with no combinational path from req or count to any output.
REQ-013 Arbitration SHALL be round-robin: search req starting at index ptr, ascending modulo 4; the first set bit wins.
REQ-014 In IDLE: gnt=0, cnt_en=0, cnt_clr=0. If req!=0, go to LOAD and latch the winner into owner.
REQ-015 In LOAD (exactly 1 cycle): gnt[owner]=1, cnt_clr=1, cnt_en=0. Go to RELEASE if req[owner]=0, else go to HOLD.
REQ-016 In HOLD: gnt[owner]=1, cnt_clr=0, cnt_en=1 except when count==HOLD_MAX-1, where cnt_en=0 (the counter saturates and never wraps).
REQ-017 HOLD transitions, checked in priority order:
- req[owner]=0 -> RELEASE (voluntary release).
- count==HOLD_MAX-1 and (req & ~gnt)!=0 -> RELEASE, with preempt=1 for that one cycle.
- Otherwise stay in HOLD.
REQ-018 In RELEASE (exactly 1 cycle): gnt=0, cnt_en=0, cnt_clr=0, ptr<=owner+1 mod 4. Re-arbitrate with the updated pointer: if req!=0, go to LOAD with the new winner; else go to IDLE.
REQ-019 A releasing owner still requesting SHALL be the lowest priority in the RELEASE arbitration; it wins only if no other bit of req is set.
REQ-020 gnt SHALL never have more than one bit set. There SHALL be at least one gnt=0 cycle (RELEASE) between any two grants.
REQ-021 A requester SHALL hold req until it sees gnt. Req deassertion while not granted SHALL be tolerated with no effect.
REQ-022 With HOLD_MAX=1: count==0 in the first HOLD cycle, so cnt_en=0 throughout HOLD and preemption is possible on the first HOLD cycle.
REQ-023 owner SHALL retain its value in IDLE and RELEASE. busy=0 only in IDLE.
REQ-024 Simultaneous voluntary release and expiry SHALL be reported as voluntary, with preempt=0.

Reset
REQ-025 Reset assertion SHALL immediately, independent of clock, force state=IDLE, gnt=0, owner=0, ptr=0, cnt_clr=0, cnt_en=0, preempt=0, busy=0.
REQ-026 Reset mid-grant SHALL drop gnt at once with no RELEASE cycle. After release, requester 0 has first priority.
REQ-027 After reset deasserts, the first arbitration SHALL occur on the first rising edge at which req!=0.

Verification
REQ-028 Single requester, HOLD_MAX=8: req=0010 held for 20 cycles, then dropped.
- gnt=0010 one cycle after req.
- cnt_clr high for exactly 1 cycle.
- count rises 0..7 and then holds at 7.
- preempt never pulses.
- After the drop: one RELEASE cycle, then IDLE.
REQ-029 Contention: req=0011 held continuously, HOLD_MAX=4.
- Grants alternate 0001, 0010, 0001, ...
- Each grant lasts 1 LOAD + 4 HOLD cycles, followed by preempt=1 and one gnt=0 cycle.
REQ-030 All four requesting, voluntary 2-cycle tenures:
- Grant order is 0,1,2,3,0.
- gnt is one-hot or zero every cycle.
REQ-031 Release during LOAD: owner drops req in its LOAD cycle -> RELEASE next cycle, no HOLD, cnt_en never asserted.
REQ-032 Reset asserted mid-HOLD with owner=2:
- gnt=0 within the same cycle, asynchronously.
- After deassert with req=1111, first gnt=0001.
REQ-033 HOLD_MAX=1 with req=0101:
- Each owner gets 1 LOAD + 1 HOLD cycle.
- preempt pulses every grant.
- cnt_en stays 0 throughout.
